spi_controller: RTL and testbench

- SPI mode-0 write-only initiator that drives the chip's SPI register interface.
- Accepts one register-write command per valid/ready handshake and serialises it as one 16-bit frame, MSB first: {rw, addr[6:0], data[7:0]}.
- Generates SCLK, nCS and COPI from the system clock at a configurable rate.
- Used as the on-chip/test-harness master that programs the output-enable, PWM-enable and PWM duty-cycle registers.

---
 rtl/spi_controller.sv | 126 ++++++++++++
 tb/tb_spi_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI mode-0 write-only initiator: one 16-bit {rw, addr, data} frame per accepted command,
// MSB first, followed by a guaranteed nCS-high gap before the next command is taken.
module spi_controller #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic       SCLK,
  output logic       nCS,
  output logic       COPI
);

  localparam logic [7:0] DivLoad = 8'(CLK_DIV - 1);
  localparam logic [7:0] GapLoad = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShiftHi,
    StShiftLo,
    StHold,
    StGap
  } state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  bit_q;
  logic [15:0] shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      bit_q     <= 4'd0;
      shift_q   <= 16'd0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      SCLK      <= 1'b0;
      nCS       <= 1'b1;
      COPI      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            nCS       <= 1'b0;
            shift_q   <= {cmd_rw, cmd_addr, cmd_data};
            COPI      <= cmd_rw;
            cnt_q     <= DivLoad;
            bit_q     <= 4'd0;
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == 8'd0) begin
            SCLK    <= 1'b1;
            cnt_q   <= DivLoad;
            state_q <= StShiftHi;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StShiftHi: begin
          if (cnt_q == 8'd0) begin
            SCLK  <= 1'b0;
            cnt_q <= DivLoad;
            bit_q <= bit_q + 4'd1;
            // The last bit stays on COPI through HOLD; only earlier falls advance the data.
            if (bit_q == 4'd15) begin
              state_q <= StHold;
            end else begin
              shift_q <= {shift_q[14:0], 1'b0};
              COPI    <= shift_q[14];
              state_q <= StShiftLo;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StShiftLo: begin
          if (cnt_q == 8'd0) begin
            SCLK    <= 1'b1;
            cnt_q   <= DivLoad;
            state_q <= StShiftHi;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StHold: begin
          if (cnt_q == 8'd0) begin
            nCS     <= 1'b1;
            COPI    <= 1'b0;
            cnt_q   <= GapLoad;
            state_q <= StGap;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StGap: begin
          if (cnt_q == 8'd0) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Randomised bench for spi_controller: a bus monitor decodes frames and timing from the pins
// and compares them with the commands handed over plus the closed-form frame timing.
module tb_spi_controller;

  localparam int unsigned CD  = 4;
  localparam int unsigned GAP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = 7'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       cmd_ready, busy, done, SCLK, nCS, COPI;

  spi_controller #(
    .CLK_DIV   (CD),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_rw   (cmd_rw),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .busy     (busy),
    .done     (done),
    .SCLK     (SCLK),
    .nCS      (nCS),
    .COPI     (COPI)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [15:0] exp_frames[64];
  int          wr_idx = 0;
  int          rd_idx = 0;
  int          rises = 0;
  int          falls = 0;
  int          frame_start = 0;
  int          last_ncs_rise = -1;
  int          done_at = -1;
  int          done_cnt = 0;
  logic [15:0] rx = 16'd0;
  logic [15:0] last_rx = 16'd0;
  logic [7:0]  regs[128];
  bit          b2b = 1'b0;
  int          b2b_start = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Pin-level monitor: one sample per negedge, cyc counts clk edges.
  task automatic monitor();
    logic p_sclk = 1'b0;
    logic p_ncs = 1'b1;
    logic p_copi = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        rd_idx  = wr_idx;
        done_at = -1;
        p_sclk  = 1'b0;
        p_ncs   = 1'b1;
        p_copi  = 1'b0;
      end else begin
        if (p_ncs && !nCS) begin
          frame_start = cyc;
          rises = 0;
          falls = 0;
          rx = 16'd0;
          check("busy_at_start", 32'(busy), 32'd1);
          if (b2b && last_ncs_rise > b2b_start)
            check("b2b_ncs_high_cycles", 32'(cyc - last_ncs_rise), 32'(GAP + 1));
        end
        if (!p_sclk && SCLK) begin
          check("rise_time", 32'(cyc), 32'(frame_start + int'(CD) * (2 * rises + 1)));
          check("copi_stable_at_rise", 32'(COPI), 32'(p_copi));
          check("rise_inside_frame", 32'(!nCS && rises < 16), 32'd1);
          rx = {rx[14:0], COPI};
          rises++;
        end
        if (p_sclk && !SCLK) begin
          check("fall_time", 32'(cyc), 32'(frame_start + int'(CD) * (2 * falls + 2)));
          falls++;
        end
        if (!p_ncs && nCS) begin
          check("frame_rises", 32'(rises), 32'd16);
          check("frame_falls", 32'(falls), 32'd16);
          check("ncs_rise_time", 32'(cyc), 32'(frame_start + 33 * int'(CD)));
          check("copi_idle_after_frame", 32'(COPI), 32'd0);
          if (rd_idx < wr_idx) begin
            check("frame_data", 32'(rx), 32'(exp_frames[rd_idx % 64]));
            rd_idx++;
          end else begin
            check("frame_unexpected", 32'd1, 32'd0);
          end
          last_rx = rx;
          if (rx[15]) regs[rx[14:8]] = rx[7:0];
          done_at = cyc + int'(GAP);
          last_ncs_rise = cyc;
        end
        if (done) begin
          check("done_time", 32'(cyc), 32'(done_at));
          check("busy_low_at_done", 32'(busy), 32'd0);
          check("ready_at_done", 32'(cmd_ready), 32'd1);
          done_at = -1;
          done_cnt++;
        end
        p_sclk = SCLK;
        p_ncs  = nCS;
        p_copi = COPI;
      end
    end
  endtask

  task automatic send(input logic [15:0] f, input bit hold);
    int n = 0;
    @(negedge clk);
    #1;
    cmd_valid = 1'b1;
    {cmd_rw, cmd_addr, cmd_data} = f;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (b2b && n > 0) check("b2b_accept_on_done", 32'(done), 32'd1);
    exp_frames[wr_idx % 64] = f;
    wr_idx++;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    {cmd_rw, cmd_addr, cmd_data} = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((rd_idx != wr_idx || busy || done_at != -1) && n < 5000);
    check("idle_reached", 32'(n < 5000), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] f;
    int          dc;
    int          n;
    fork
      monitor();
    join_none

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_sclk", 32'(SCLK), 32'd0);
    check("rst_ncs", 32'(nCS), 32'd1);
    check("rst_copi", 32'(COPI), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    check("ready_before_first_edge", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_release", 32'(cmd_ready), 32'd1);
    check("busy_after_release", 32'(busy), 32'd0);

    // Single write: rw=1, addr=0x04, data=0xA5.
    send(16'h84A5, 1'b0);
    wait_idle();
    check("single_frame_bits", 32'(last_rx), 32'h84A5);

    // Register loopback through a behavioural peripheral.
    send({1'b1, 7'd0, 8'hFF}, 1'b0); wait_idle();
    send({1'b1, 7'd1, 8'h01}, 1'b0); wait_idle();
    send({1'b1, 7'd2, 8'h80}, 1'b0); wait_idle();
    send({1'b1, 7'd3, 8'h3C}, 1'b0); wait_idle();
    send({1'b1, 7'd4, 8'h7F}, 1'b0); wait_idle();
    send({1'b0, 7'd0, 8'h00}, 1'b0); wait_idle();
    check("reg0", 32'(regs[0]), 32'hFF);
    check("reg1", 32'(regs[1]), 32'h01);
    check("reg2", 32'(regs[2]), 32'h80);
    check("reg3", 32'(regs[3]), 32'h3C);
    check("reg4", 32'(regs[4]), 32'h7F);

    // Back-to-back with cmd_valid held high.
    dc = done_cnt;
    b2b_start = cyc;
    b2b = 1'b1;
    for (int i = 0; i < 3; i++) send(16'($urandom), 1'b1);
    cmd_valid = 1'b0;
    wait_idle();
    b2b = 1'b0;
    check("b2b_done_count", 32'(done_cnt - dc), 32'd3);

    // Input churn while busy must neither alter nor add frames.
    dc = done_cnt;
    f = 16'($urandom);
    send(f, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_data = 8'($urandom);
      @(negedge clk);
      #1;
      cmd_valid = 1'b0;
    end
    wait_idle();
    check("busy_churn_frame", 32'(last_rx), 32'(f));
    check("busy_churn_done_count", 32'(done_cnt - dc), 32'd1);

    // Randomised single frames.
    for (int i = 0; i < 6; i++) begin
      send(16'($urandom), 1'b0);
      wait_idle();
    end

    // Reset after the 7th SCLK rise, then a clean frame.
    send(16'($urandom), 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (rises < 7 && n < 1000);
    check("reached_7th_rise", 32'(rises), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ncs", 32'(nCS), 32'd1);
    check("midrst_sclk", 32'(SCLK), 32'd0);
    check("midrst_copi", 32'(COPI), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    dc = done_cnt;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt), 32'(dc));
    f = 16'($urandom);
    send(f, 1'b0);
    wait_idle();
    check("post_reset_frame", 32'(last_rx), 32'(f));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
